// File: rtl/mc97_ring_ctrl_if.sv
// mc97_ring_ctrl_if: line/host signal bundle for the ring controller.
// Defining MC97_RING_CALLERID_EN adds the cid_window status bit.
interface mc97_ring_ctrl_if;
    logic       rfi;
    logic       cfg_en;
    logic [3:0] cfg_auto_rings;
    logic       host_answer;
    logic       host_hangup;
    logic       offhook;
    logic [3:0] ring_cnt;
    logic       ring_stb;
    logic       ringing;
    logic       call_active;
`ifdef MC97_RING_CALLERID_EN
    logic       cid_window;
    modport master (output rfi, cfg_en, cfg_auto_rings, host_answer, host_hangup,
                    input offhook, ring_cnt, ring_stb, ringing, call_active, cid_window);
    modport slave  (input rfi, cfg_en, cfg_auto_rings, host_answer, host_hangup,
                    output offhook, ring_cnt, ring_stb, ringing, call_active, cid_window);
`else
    modport master (output rfi, cfg_en, cfg_auto_rings, host_answer, host_hangup,
                    input offhook, ring_cnt, ring_stb, ringing, call_active);
    modport slave  (input rfi, cfg_en, cfg_auto_rings, host_answer, host_hangup,
                    output offhook, ring_cnt, ring_stb, ringing, call_active);
`endif
endinterface

// File: rtl/mc97_ring_ctrl.sv
// mc97_ring_ctrl: ring cadence qualifier and answer sequencer driving the hook relay.
// Optional caller-ID window output enabled by defining MC97_RING_CALLERID_EN.
module mc97_ring_ctrl #(
    parameter int CLK_FREQ     = 24_000_000,
    parameter int RING_MIN_MS  = 200,
    parameter int PAUSE_MAX_MS = 8000,
    parameter int GUARD_MS     = 500
) (
    input logic              clk,
    input logic              rst_n,
    mc97_ring_ctrl_if.slave  bus
);
    localparam int DIV = CLK_FREQ / 1000;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RING   = 3'd1;
    localparam logic [2:0] S_PAUSE  = 3'd2;
    localparam logic [2:0] S_ONLINE = 3'd3;
    localparam logic [2:0] S_GUARD  = 3'd4;

    logic [2:0]    r_state, w_nxt;
    logic [PW-1:0] r_pre;
    logic [13:0]   r_ms;
    logic [3:0]    r_cnt;
    logic          r_counted, r_stb, r_online, r_ringing;
    logic          w_tick, w_ans, w_auto, w_inc, w_entry;

    // hangup wins over a simultaneous answer
    assign w_ans   = bus.host_answer & ~bus.host_hangup;
    assign w_tick  = r_pre == PW'(DIV - 1);
    assign w_auto  = (r_state == S_RING || r_state == S_PAUSE) && (|bus.cfg_auto_rings)
                     && r_cnt >= bus.cfg_auto_rings;
    assign w_inc   = r_state == S_RING && bus.rfi && !r_counted && r_ms >= 14'(RING_MIN_MS);
    assign w_entry = w_nxt != r_state;

    always_comb begin
        w_nxt = S_IDLE;
        if (bus.cfg_en)
            case (r_state)
                S_IDLE:   w_nxt = w_ans ? S_ONLINE : bus.rfi ? S_RING : S_IDLE;
                S_RING:   w_nxt = (w_ans || w_auto) ? S_ONLINE : bus.rfi ? S_RING : S_PAUSE;
                S_PAUSE:  w_nxt = (w_ans || w_auto) ? S_ONLINE : bus.rfi ? S_RING :
                                  r_ms >= 14'(PAUSE_MAX_MS) ? S_IDLE : S_PAUSE;
                S_ONLINE: w_nxt = bus.host_hangup ? S_GUARD : S_ONLINE;
                S_GUARD:  w_nxt = r_ms >= 14'(GUARD_MS) ? S_IDLE : S_GUARD;
                default:  w_nxt = S_IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_ms      <= '0;
            r_cnt     <= '0;
            r_counted <= 1'b0;
            r_stb     <= 1'b0;
            r_online  <= 1'b0;
            r_ringing <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_pre     <= w_tick ? '0 : r_pre + 1'b1;
            r_ms      <= w_entry ? '0 : (w_tick && r_ms != '1) ? r_ms + 1'b1 : r_ms;
            r_counted <= w_entry ? 1'b0 : r_counted | w_inc;
            r_stb     <= w_inc;
            r_cnt     <= (w_nxt == S_IDLE || w_nxt == S_ONLINE) ? '0 :
                         (w_inc && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
            r_online  <= w_nxt == S_ONLINE;
            r_ringing <= w_nxt == S_RING || w_nxt == S_PAUSE;
        end
    end

    assign bus.offhook     = r_online;
    assign bus.call_active = r_online;
    assign bus.ring_cnt    = r_cnt;
    assign bus.ring_stb    = r_stb;
    assign bus.ringing     = r_ringing;

`ifdef MC97_RING_CALLERID_EN
    logic r_cid;
    // open after the first ring ends, held through that pause only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cid <= 1'b0;
        else
            r_cid <= w_nxt == S_PAUSE && (r_state == S_PAUSE ? r_cid : r_cnt == 4'd1);
    end
    assign bus.cid_window = r_cid;
`endif
endmodule
